// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapaths: FSM state
// encoding and the bit-counter width helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must index bits 0..w-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder used as the serial adder's bit cell.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, a registered carry and
// shift registers, sequenced by an IDLE/RUN/DONE controller.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output state_t           state_dbg
);

   // Handshake: start is sampled only in IDLE; an accepted start latches
   // a/b/cin and raises busy for WIDTH cycles, then done pulses for one
   // cycle with sum/cout valid and held until the next accepted start.
   // start seen in RUN or DONE is dropped, never queued.

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] shift_a_q, shift_b_q, sum_q;
   logic             cout_q;
   logic             fa_s, fa_co;
   logic             last_bit;

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   full_adder u_fa (
      .x  (shift_a_q[0]),
      .y  (shift_b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         shift_a_q <= '0;
         shift_b_q <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  shift_a_q <= a;
                  shift_b_q <= b;
                  carry_q   <= cin;
                  cnt_q     <= '0;
               end
            end
            RUN: begin
               // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
               sum_q     <= {fa_s, sum_q[WIDTH-1:1]};
               shift_a_q <= {1'b0, shift_a_q[WIDTH-1:1]};
               shift_b_q <= {1'b0, shift_b_q[WIDTH-1:1]};
               carry_q   <= fa_co;
               cnt_q     <= cnt_q + CW'(1);
               if (last_bit) cout_q <= fa_co;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and back-to-back checks of serial_adder at WIDTH=8.
module tb_serial_adder;
   import serial_arith_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   state_t       state_dbg;

   int checks = 0;
   int errors = 0;
   logic [W:0] exp_q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation at a negedge and wait (bounded) for done.
   // lat counts negedges after the accepting edge up to and including done.
   task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                           output logic [W-1:0] s, output logic co,
                           output int lat, output int busy_cnt);
      a = av; b = bv; cin = cv; start = 1'b1;
      lat = 0; busy_cnt = 0;
      s = '0; co = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (busy) busy_cnt++;
         if (done) begin
            s = sum; co = cout;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, cout} !== 3'b000 || sum !== '0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b cout=%b sum=%h state=%0d, want all 0 / IDLE",
                  busy, done, cout, sum, state_dbg);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [W-1:0] s; logic co; int lat, bc;
      logic [W-1:0] av[3] = '{8'h00, 8'h25, 8'h02};
      logic [W-1:0] bv[3] = '{8'h00, 8'h1A, 8'h03};
      logic [W-1:0] es[3] = '{8'h00, 8'h3F, 8'h05};
      for (int i = 0; i < 3; i++) begin
         drive_op(av[i], bv[i], 1'b0, s, co, lat, bc);
         checks++;
         if (lat !== 9 || bc !== 8) begin
            errors++;
            $display("FAIL basic_timing[%0d]: latency=%0d busy_cycles=%0d, want 9/8", i, lat, bc);
         end
         checks++;
         if (s !== es[i] || co !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum[%0d]: sum=%h cout=%b, want %h/0", i, s, co, es[i]);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_done[%0d]: busy=%b, want 0", i, busy);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL basic_done_pulse[%0d]: done=%b state=%0d, want 0/IDLE", i, done, state_dbg);
         end
      end
   endtask

   task automatic test_carry();
      logic [W-1:0] s; logic co; int lat, bc;
      drive_op(8'hFF, 8'h01, 1'b0, s, co, lat, bc);
      checks++;
      if (s !== 8'h00 || co !== 1'b1) begin
         errors++;
         $display("FAIL carry_ff_01: sum=%h cout=%b, want 00/1", s, co);
      end
      @(negedge clk);
      drive_op(8'hFF, 8'hFF, 1'b1, s, co, lat, bc);
      checks++;
      if (s !== 8'hFF || co !== 1'b1) begin
         errors++;
         $display("FAIL carry_ff_ff_1: sum=%h cout=%b, want FF/1", s, co);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int n_done = 0;
      int cyc = 0;
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (done) n_done++;
         // Conflicting requests during RUN (cycle 3) and DONE (cycle 9).
         if (cyc == 3 || cyc == 9) begin
            a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
         end
         if (cyc == 9) begin
            checks++;
            if (done !== 1'b1 || sum !== 8'h30 || cout !== 1'b0) begin
               errors++;
               $display("FAIL ignore_result: done=%b sum=%h cout=%b, want 1/30/0", done, sum, cout);
            end
         end
         if (cyc > 9) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL ignore_no_restart: cycle %0d busy=%b, want 0", cyc, busy);
            end
         end
      end
      checks++;
      if (n_done !== 1 || sum !== 8'h30) begin
         errors++;
         $display("FAIL ignore_single_done: dones=%0d sum=%h, want 1/30", n_done, sum);
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] s; logic co; int lat, bc;
      int n_done = 0;
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) n_done++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, cout} !== 3'b000 || sum !== '0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%h state=%0d, want 0s/IDLE",
                  busy, done, cout, sum, state_dbg);
      end
      repeat (3) begin
         @(negedge clk);
         if (done) n_done++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL async_no_done: dones=%0d, want 0", n_done);
      end
      drive_op(8'h01, 8'h01, 1'b0, s, co, lat, bc);
      checks++;
      if (s !== 8'h02 || co !== 1'b0 || lat !== 9) begin
         errors++;
         $display("FAIL async_recover: sum=%h cout=%b latency=%0d, want 02/0/9", s, co, lat);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int issued = 0, seen = 0, since = 0, last_gap = -1, idle = 0;
      logic [W:0] exp;
      a = W'($urandom_range(255)); b = W'($urandom_range(255)); cin = 1'($urandom_range(1));
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      issued = 1;
      start = 1'b1;
      while (seen < 1000) begin
         @(negedge clk);
         since++;
         idle++;
         if (idle > 40) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: no done for 40 cycles after %0d results", seen);
            break;
         end
         if (done) begin
            idle = 0;
            exp = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== exp) begin
               errors++;
               $display("FAIL b2b_sum[%0d]: got %h, want %h", seen, {cout, sum}, exp);
            end
            if (seen > 0) begin
               checks++;
               if (since !== 10) begin
                  errors++;
                  $display("FAIL b2b_spacing[%0d]: %0d cycles, want 10", seen, since);
               end
            end
            since = 0;
            seen++;
            if (issued < 1000) begin
               a = W'($urandom_range(255)); b = W'($urandom_range(255)); cin = 1'($urandom_range(1));
               exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
               issued++;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
